// File: rtl/parity_tx.sv
`default_nettype none
// ============================================================================
// Module   : parity_tx
// Purpose  : Serial transmitter sending one byte per frame as
//            start(0), data LSB first, supplied parity bit, stop(1). Each bit
//            is held for CLKS_PER_BIT clocks. One-byte capture, no queuing.
// Macro    : PARITY_CHECK_EN -- when defined, the supplied parity is checked
//            against the captured byte and parity_err pulses for the first
//            START cycle on a mismatch (the supplied bit is still sent).
// Revision : 1.0 -- initial release
// ============================================================================
module parity_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in,
  input  logic       parity,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       parity_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam logic [7:0] c_cnt_max = 8'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       in_ready_q, in_ready_d;
  logic       busy_q, busy_d;
  logic       parity_err_q, parity_err_d;

  logic       handshake;
  logic       bit_done;

  assign handshake = (state_q == IDLE) && in_ready_q && in_valid;
  assign bit_done  = (cnt_q == c_cnt_max);

  // Next-state, bit-period counter and data-bit index; capture on handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          data_d  = in;
          par_d   = parity;
          cnt_d   = 8'd0;
          idx_d   = 3'd0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_d   = 8'd0;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = 8'd0;
          // index wraps 7->0 as the frame moves on to the parity bit
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = PAR;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PAR: begin
        if (bit_done) begin
          cnt_d   = 8'd0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        idx_d   = 3'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered versions line
  // up with the state they belong to (tx=0 the cycle after the handshake)
  always_comb begin
    tx_d       = 1'b1;
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[idx_d];
      PAR:     tx_d = par_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
`ifdef PARITY_CHECK_EN
    // high only on the capture edge, so the pulse covers the first START cycle
    parity_err_d = handshake && ((^in) != parity);
`else
    parity_err_d = 1'b0;
`endif
  end

  // State and registered outputs; synchronous active-low reset aborts any frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      idx_q        <= 3'd0;
      data_q       <= 8'd0;
      par_q        <= 1'b0;
      tx_q         <= 1'b1;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      par_q        <= par_d;
      tx_q         <= tx_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign tx         = tx_q;
  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign parity_err = parity_err_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_tx
// Purpose  : Self-checking bench for parity_tx. Instance A uses
//            CLKS_PER_BIT=4, instance B uses CLKS_PER_BIT=1. Expected line
//            values come from an 11-slot frame built from the byte and parity.
// Macro    : PARITY_CHECK_EN changes the expected parity_err behaviour.
// Revision : 1.0 -- initial release
// ============================================================================
module tb_parity_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       parity_in;
  logic       valid_a, valid_b;
  logic       ready_a, tx_a, busy_a, perr_a;
  logic       ready_b, tx_b, busy_b, perr_b;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  parity_tx #(.CLKS_PER_BIT(4)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in_data),
    .parity     (parity_in),
    .in_valid   (valid_a),
    .in_ready   (ready_a),
    .tx         (tx_a),
    .busy       (busy_a),
    .parity_err (perr_a)
  );

  parity_tx #(.CLKS_PER_BIT(1)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in_data),
    .parity     (parity_in),
    .in_valid   (valid_b),
    .in_ready   (ready_b),
    .tx         (tx_b),
    .busy       (busy_b),
    .parity_err (perr_b)
  );

  // Line level for frame slot 0..10: start, d[0]..d[7], parity, stop
  function automatic logic frame_bit(input logic [7:0] d, input logic p, input int slot);
    logic [10:0] frame;
    frame = {1'b1, p, d, 1'b0};
    return frame[slot];
  endfunction

  // parity_err expectation for frame cycle k
  function automatic logic exp_err(input logic [7:0] d, input logic p, input int k);
`ifdef PARITY_CHECK_EN
    return (k == 0) && ((^d) != p);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame from the IDLE cycle and checks every cycle of it plus the
  // following IDLE cycle. hold keeps in_valid high; toggle scrambles in/parity.
  task automatic send_frame(input bit use_b, input logic [7:0] d, input logic p,
                            input bit hold, input bit toggle);
    int cpb;
    cpb = use_b ? 1 : 4;
    check($sformatf("ready_pre %s %02h", use_b ? "B" : "A", d), use_b ? ready_b : ready_a, 1'b1);
    in_data   = d;
    parity_in = p;
    if (use_b) valid_b = 1'b1; else valid_a = 1'b1;
    step();
    if (!hold) begin
      valid_a = 1'b0;
      valid_b = 1'b0;
    end
    for (int k = 0; k < 11 * cpb; k++) begin
      check($sformatf("tx %02h k=%0d", d, k), use_b ? tx_b : tx_a, frame_bit(d, p, k / cpb));
      check($sformatf("busy %02h k=%0d", d, k), use_b ? busy_b : busy_a, 1'b1);
      check($sformatf("ready %02h k=%0d", d, k), use_b ? ready_b : ready_a, 1'b0);
      check($sformatf("perr %02h k=%0d", d, k), use_b ? perr_b : perr_a, exp_err(d, p, k));
      if (toggle) begin
        in_data   = 8'($urandom);
        parity_in = 1'($urandom);
      end
      step();
    end
    check($sformatf("idle tx %02h", d), use_b ? tx_b : tx_a, 1'b1);
    check($sformatf("idle busy %02h", d), use_b ? busy_b : busy_a, 1'b0);
    check($sformatf("idle ready %02h", d), use_b ? ready_b : ready_a, 1'b1);
  endtask

  initial begin
    logic [7:0] d;
    logic       p;

    // reset, with in_valid asserted to show it is ignored
    rst_n     = 1'b0;
    valid_a   = 1'b1;
    valid_b   = 1'b0;
    in_data   = 8'h5A;
    parity_in = 1'b0;
    repeat (3) step();
    check("rst tx A", tx_a, 1'b1);
    check("rst busy A", busy_a, 1'b0);
    check("rst ready A", ready_a, 1'b0);
    check("rst perr A", perr_a, 1'b0);
    check("rst tx B", tx_b, 1'b1);
    check("rst ready B", ready_b, 1'b0);

    // first edge with rst_n high: ready, no frame started
    rst_n = 1'b1;
    step();
    check("release ready A", ready_a, 1'b1);
    check("release busy A", busy_a, 1'b0);
    check("release tx A", tx_a, 1'b1);
    valid_a = 1'b0;
    step();

    // basic frame
    send_frame(1'b0, 8'hA7, 1'b1, 1'b0, 1'b0);

    // back-to-back with in_valid held high
    send_frame(1'b0, 8'h03, 1'b0, 1'b1, 1'b0);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);
    valid_a = 1'b0;
    step();
    check("b2b no third frame", busy_a, 1'b0);

    // wrong supplied parity, transmitted uncorrected
    send_frame(1'b0, 8'h15, 1'b0, 1'b0, 1'b0);

    // inputs toggling during the frame
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // one clock per bit
    send_frame(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);

    // random frames on both instances, some with wrong parity
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      send_frame(i[0], d, p, 1'b0, (i % 3) == 0);
    end

    // reset in the middle of data bit 3
    in_data   = 8'hC3;
    parity_in = 1'b0;
    valid_a   = 1'b1;
    step();
    valid_a = 1'b0;
    repeat (17) step();
    check("abort pre tx", tx_a, frame_bit(8'hC3, 1'b0, 4));
    check("abort pre busy", busy_a, 1'b1);
    rst_n = 1'b0;
    step();
    check("abort tx", tx_a, 1'b1);
    check("abort busy", busy_a, 1'b0);
    check("abort ready", ready_a, 1'b0);
    rst_n = 1'b1;
    step();
    check("abort release ready", ready_a, 1'b1);
    for (int k = 0; k < 48; k++) begin
      check($sformatf("abort idle tx k=%0d", k), tx_a, 1'b1);
      check($sformatf("abort idle busy k=%0d", k), busy_a, 1'b0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
